// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the serial-MAC FIR control sequencer.
//   - seq_state_t : sequencer state encoding
//   - DEFAULT_TAPS / DEFAULT_ADDR_W : default filter geometry
//   - wrap_sub    : (a - b) mod taps for a, b already in 0..taps-1
package fir_pkg;

    localparam int DEFAULT_TAPS   = 4;
    localparam int DEFAULT_ADDR_W = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

    // The delay line holds exactly 'taps' entries, which need not be a power
    // of two, so the wrap is an explicit add of 'taps' instead of letting the
    // address bits truncate.
    function automatic int unsigned wrap_sub(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned taps);
        if (a >= b) begin
            return a - b;
        end
        return a + taps - b;
    endfunction

endpackage

// File: rtl/fir_tap_addr_gen.sv
// fir_tap_addr_gen: tap counter, write pointer and wrapped delay-line address.
//   clk, global_reset : clock, synchronous active-high reset
//   k_run             : count k this cycle (k wraps to 0 after TAPS-1,
//                       and is held at 0 while k_run is low)
//   wptr_inc          : advance wptr by one, wrapping TAPS-1 -> 0
//   wptr_clr          : force wptr to 0 (wins over wptr_inc)
//   k, k_last         : tap counter and its terminal-count flag
//   wptr              : slot that the next input sample is written to
//   ram_addr          : (wptr - k) mod TAPS, the slot holding tap k
module fir_tap_addr_gen
    import fir_pkg::*;
#(
    parameter int TAPS   = DEFAULT_TAPS,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              global_reset,
    input  logic              k_run,
    input  logic              wptr_inc,
    input  logic              wptr_clr,
    output logic [ADDR_W-1:0] k,
    output logic              k_last,
    output logic [ADDR_W-1:0] wptr,
    output logic [ADDR_W-1:0] ram_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);

    assign k_last   = (k == LAST);
    assign ram_addr = ADDR_W'(wrap_sub(32'(wptr), 32'(k), 32'(TAPS)));

    always_ff @(posedge clk) begin
        if (global_reset) begin
            k    <= '0;
            wptr <= '0;
        end else begin
            if (!k_run || k_last) begin
                k <= '0;
            end else begin
                k <= k + 1'b1;
            end

            if (wptr_clr) begin
                wptr <= '0;
            end else if (wptr_inc) begin
                wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: handshake-driven control sequencer for a serial MAC FIR.
//   clk, global_reset : clock, synchronous active-high reset (all outputs
//                       are forced to 0 while reset is high)
//   in_valid/in_ready : sample handshake; a transfer happens in a cycle where
//                       both are 1. in_ready is 1 only in IDLE, and in_valid
//                       while in_ready=0 is ignored, so upstream must hold the
//                       sample (xn) stable until accepted and through the
//                       following WRITE cycle. flush is sampled under the
//                       same in_ready and wins over in_valid.
//   wr, zero_sel      : RAM write enable, write zero instead of xn
//   add_ram, add_rom  : RAM / coefficient ROM addresses
//   ld1, ld2          : load coefficient / sample operand registers
//   acc_clr, acc_en   : clear accumulator / add multiplier product
//   out_valid         : one-cycle pulse, accumulator holds y[n]
//   busy              : high in every state except IDLE
//   state             : current sequencer state (IDLE while in reset)
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int TAPS   = DEFAULT_TAPS,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              global_reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              wr,
    output logic              zero_sel,
    output logic [ADDR_W-1:0] add_ram,
    output logic [ADDR_W-1:0] add_rom,
    output logic              ld1,
    output logic              ld2,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              out_valid,
    output logic              busy,
    output seq_state_t        state
);

    seq_state_t        state_q;
    seq_state_t        state_next;
    logic [ADDR_W-1:0] k;
    logic              k_last;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] tap_addr;
    logic              k_run;
    logic              wptr_inc;
    logic              wptr_clr;

    // Ungated Moore decode; the reset gate is applied on the ports below.
    logic              ready_d;
    logic              wr_d;
    logic              zero_sel_d;
    logic [ADDR_W-1:0] add_ram_d;
    logic [ADDR_W-1:0] add_rom_d;
    logic              ld_d;
    logic              acc_clr_d;
    logic              acc_en_d;
    logic              out_valid_d;

    assign k_run    = (state_q == MAC) || (state_q == FLUSH);
    assign wptr_inc = (state_q == DONE);
    assign wptr_clr = (state_q == FLUSH) && k_last;

    fir_tap_addr_gen #(
        .TAPS   (TAPS),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk          (clk),
        .global_reset (global_reset),
        .k_run        (k_run),
        .wptr_inc     (wptr_inc),
        .wptr_clr     (wptr_clr),
        .k            (k),
        .k_last       (k_last),
        .wptr         (wptr),
        .ram_addr     (tap_addr)
    );

    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_next = FLUSH;
                end else if (in_valid) begin
                    state_next = WRITE;
                end
            end
            WRITE:   state_next = MAC;
            MAC:     state_next = k_last ? DRAIN : MAC;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            FLUSH:   state_next = k_last ? IDLE : FLUSH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (global_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        ready_d     = 1'b0;
        wr_d        = 1'b0;
        zero_sel_d  = 1'b0;
        add_ram_d   = '0;
        add_rom_d   = '0;
        ld_d        = 1'b0;
        acc_clr_d   = 1'b0;
        acc_en_d    = 1'b0;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: ready_d = 1'b1;
            WRITE: begin
                wr_d      = 1'b1;
                add_ram_d = wptr;
                acc_clr_d = 1'b1;
            end
            MAC: begin
                add_rom_d = k;
                add_ram_d = tap_addr;
                ld_d      = 1'b1;
                // Operands are registered, so the product seen by the
                // accumulator belongs to the previous tap.
                acc_en_d  = (k != '0);
            end
            DRAIN: acc_en_d = 1'b1;
            DONE:  out_valid_d = 1'b1;
            FLUSH: begin
                wr_d       = 1'b1;
                zero_sel_d = 1'b1;
                add_ram_d  = k;
            end
            default: ;
        endcase
    end

    assign in_ready  = !global_reset && ready_d;
    assign wr        = !global_reset && wr_d;
    assign zero_sel  = !global_reset && zero_sel_d;
    assign add_ram   = global_reset ? '0 : add_ram_d;
    assign add_rom   = global_reset ? '0 : add_rom_d;
    assign ld1       = !global_reset && ld_d;
    assign ld2       = !global_reset && ld_d;
    assign acc_clr   = !global_reset && acc_clr_d;
    assign acc_en    = !global_reset && acc_en_d;
    assign out_valid = !global_reset && out_valid_d;
    assign busy      = !global_reset && (state_q != IDLE);
    assign state     = global_reset ? IDLE : state_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed bench for fir_mac_sequencer (TAPS=4).
// The bench owns a datapath (ROM, RAM, operand registers, accumulator)
// driven by the sequencer outputs, a cycle-offset model of the expected
// control outputs, and a tap-ordered delay-line model producing y[n].
module tb_fir_mac_sequencer;
    import fir_pkg::*;

    localparam int TAPS   = 4;
    localparam int ADDR_W = 2;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              global_reset;
    logic              in_valid;
    logic              flush;
    logic [7:0]        xn;
    logic              in_ready;
    logic              wr;
    logic              zero_sel;
    logic [ADDR_W-1:0] add_ram;
    logic [ADDR_W-1:0] add_rom;
    logic              ld1;
    logic              ld2;
    logic              acc_clr;
    logic              acc_en;
    logic              out_valid;
    logic              busy;
    seq_state_t        state;

    always #5 clk = ~clk;

    fir_mac_sequencer #(.TAPS(TAPS), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .global_reset (global_reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .flush        (flush),
        .wr           (wr),
        .zero_sel     (zero_sel),
        .add_ram      (add_ram),
        .add_rom      (add_rom),
        .ld1          (ld1),
        .ld2          (ld2),
        .acc_clr      (acc_clr),
        .acc_en       (acc_en),
        .out_valid    (out_valid),
        .busy         (busy),
        .state        (state)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // ---------------- bench datapath and models ----------------
    int          rom [TAPS];
    int          ram [TAPS];
    int          r1 = 0;
    int          r2 = 0;
    int          acc = 0;
    int          d [TAPS];          // d[i] = sample i steps old
    logic [31:0] exp_q [$];
    int          got_y [$];
    int          m_c = 0;           // cycles since accept (0 = idle)
    bit          m_flush = 1'b0;
    int          m_wptr = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          outv_cyc = 0;
    int          n_accepts = 0;
    int          n_outv = 0;
    int          last_wr_addr = -1;

    initial begin
        for (int i = 0; i < TAPS; i++) begin
            ram[i] = 0;
            d[i]   = 0;
        end
    end

    always @(negedge clk) begin
        int   e_k, e_ram, e_rom, n_r1, n_r2, y;
        logic e_ready, e_busy, e_wr, e_zs, e_ld, e_clr, e_en, e_ov;

        // expected control outputs for this cycle
        e_ready = 0; e_busy = 0; e_wr = 0; e_zs = 0; e_ld = 0;
        e_clr = 0; e_en = 0; e_ov = 0; e_ram = 0; e_rom = 0; e_k = 0;
        if (!global_reset) begin
            if (m_c == 0) begin
                e_ready = 1;
            end else begin
                e_busy = 1;
                if (m_flush) begin
                    e_wr = 1; e_zs = 1; e_ram = m_c - 1;
                end else if (m_c == 1) begin
                    e_wr = 1; e_ram = m_wptr; e_clr = 1;
                end else if (m_c <= TAPS + 1) begin
                    e_k   = m_c - 2;
                    e_rom = e_k;
                    e_ram = (m_wptr - e_k + TAPS) % TAPS;
                    e_ld  = 1;
                    e_en  = (e_k != 0);
                end else if (m_c == TAPS + 2) begin
                    e_en = 1;
                end else begin
                    e_ov = 1;
                end
            end
        end
        check("in_ready",  int'(in_ready),  int'(e_ready));
        check("busy",      int'(busy),      int'(e_busy));
        check("wr",        int'(wr),        int'(e_wr));
        check("zero_sel",  int'(zero_sel),  int'(e_zs));
        check("add_ram",   int'(add_ram),   e_ram);
        check("add_rom",   int'(add_rom),   e_rom);
        check("ld1",       int'(ld1),       int'(e_ld));
        check("ld2",       int'(ld2),       int'(e_ld));
        check("acc_clr",   int'(acc_clr),   int'(e_clr));
        check("acc_en",    int'(acc_en),    int'(e_en));
        check("out_valid", int'(out_valid), int'(e_ov));

        // observations
        if (in_ready && in_valid && !flush) begin
            n_accepts++;
            accept_cyc = cyc;
        end
        if (wr && !zero_sel) last_wr_addr = int'(add_ram);
        if (out_valid) begin
            n_outv++;
            outv_cyc = cyc;
            got_y.push_back(acc);
            if (exp_q.size() == 0) check("y_unexpected", acc, -1);
            else check("y", acc, int'(exp_q.pop_front()));
        end

        // datapath advances over the coming edge
        n_r1 = ld1 ? rom[add_rom] : r1;
        n_r2 = ld2 ? ram[add_ram] : r2;
        if (acc_clr) acc = 0;
        else if (acc_en) acc = acc + r1 * r2;
        if (wr) ram[add_ram] = zero_sel ? 0 : int'(xn);
        r1 = n_r1;
        r2 = n_r2;

        // model advances over the coming edge
        if (global_reset) begin
            m_c = 0; m_flush = 0; m_wptr = 0;
            exp_q.delete();
        end else if (m_c == 0) begin
            if (flush) begin
                m_c = 1; m_flush = 1;
            end else if (in_valid) begin
                m_c = 1; m_flush = 0;
                for (int i = TAPS - 1; i > 0; i--) d[i] = d[i-1];
                d[0] = int'(xn);
                y = 0;
                for (int i = 0; i < TAPS; i++) y += rom[i] * d[i];
                exp_q.push_back(32'(y));
            end
        end else if (m_flush) begin
            if (m_c == TAPS) begin
                m_c = 0; m_flush = 0; m_wptr = 0;
                for (int i = 0; i < TAPS; i++) d[i] = 0;
            end else begin
                m_c++;
            end
        end else begin
            if (m_c == TAPS + 3) begin
                m_c = 0;
                m_wptr = (m_wptr + 1) % TAPS;
            end else begin
                m_c++;
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int x);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        xn = 8'(x);
        in_valid = 1;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
        end
        #1 in_valid = 0;
        if (!ok) check("send_timeout", 0, 1);
        // xn stays put through the WRITE cycle
        @(posedge clk);
    endtask

    task automatic do_flush(input bit with_valid, input int x);
        @(posedge clk); #1;
        flush = 1;
        in_valid = with_valid;
        xn = 8'(x);
        @(posedge clk); #1;
        flush = 0;
        in_valid = 0;
        repeat (TAPS) @(posedge clk);
    endtask

    task automatic settle();
        repeat (TAPS + 4) @(posedge clk);
    endtask

    task automatic check_last(input string name, input int back, input int expv);
        if (got_y.size() < back) check(name, -1, expv);
        else check(name, got_y[got_y.size() - back], expv);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int snap;
        global_reset = 1; in_valid = 1; flush = 0; xn = 8'd9;
        for (int i = 0; i < TAPS; i++) rom[i] = 1;

        // reset held 3 cycles with in_valid high
        repeat (3) @(posedge clk);
        #1 global_reset = 0; in_valid = 0;
        @(negedge clk);
        check("post_reset_ready", int'(in_ready), 1);
        check("post_reset_busy", int'(busy), 0);
        check("post_reset_state", int'(state), int'(IDLE));

        // single sample
        send(5);
        settle();
        check_last("single_y", 1, 5);
        check("single_latency", outv_cyc - accept_cyc, 7);
        check("single_wr_addr", last_wr_addr, 0);

        // flush beats in_valid, then x=7 sees a clean line
        snap = n_outv;
        do_flush(1, 3);
        check("flush_no_out_valid", n_outv, snap);
        send(7);
        settle();
        check_last("after_flush_y", 1, 7);

        // wrap with five back-to-back samples
        do_flush(0, 0);
        for (int x = 1; x <= 5; x++) send(x);
        settle();
        check_last("wrap_y1", 5, 1);
        check_last("wrap_y2", 4, 3);
        check_last("wrap_y3", 3, 6);
        check_last("wrap_y4", 2, 10);
        check_last("wrap_y5", 1, 14);
        check("wrap_wr_addr", last_wr_addr, 0);

        // distinct coefficients
        rom[0] = 2; rom[1] = 3; rom[2] = 5; rom[3] = 7;
        do_flush(0, 0);
        send(1);
        send(10);
        settle();
        check_last("coef_y1", 2, 2);
        check_last("coef_y2", 1, 23);

        // reset during MAC k=2
        snap = n_outv;
        @(posedge clk); #1;
        xn = 8'd4; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1 global_reset = 1;
        repeat (2) @(posedge clk);
        #1 global_reset = 0;
        @(negedge clk);
        check("midrst_ready", int'(in_ready), 1);
        check("midrst_busy", int'(busy), 0);
        settle();
        check("midrst_no_out_valid", n_outv, snap);

        // backpressure: in_valid held for 24 cycles
        do_flush(0, 0);
        snap = n_accepts;
        @(posedge clk); #1;
        xn = 8'd2; in_valid = 1;
        repeat (24) @(posedge clk);
        #1 in_valid = 0;
        settle();
        check("bp_accepts", n_accepts - snap, 3);
        check_last("bp_y1", 3, 4);
        check_last("bp_y2", 2, 10);
        check_last("bp_y3", 1, 20);
        check("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Control sequencer for the serial MAC FIR datapath (coefficient ROM, sample RAM delay line, operand registers, multiplier, accumulator).
- Accepts one input sample per valid/ready handshake and writes it into a circular delay line in RAM.
- Steps through all TAPS coefficient/sample pairs, then pulses out_valid when the accumulator holds y[n].
- Adds a flush command that zeroes the delay line.
- Replaces the free-running controller with a handshake-driven, parameterised one.

Parameters:
TAPS, 4, number of filter taps; legal range 2..16, need not be a power of 2.
ADDR_W, 2, ROM/RAM address width; must satisfy 2**ADDR_W >= TAPS.

Ports:
clk  input  1  single clock, rising edge.
global_reset  input  1  synchronous, active-high reset.
in_valid  input  1  new sample present on the datapath xn bus.
in_ready  output  1  sequencer can accept a sample (or a flush) this cycle.
flush  input  1  request to zero the delay line; sampled only when in_ready=1.
wr  output  1  RAM write enable.
zero_sel  output  1  selects 0 instead of xn as RAM write data.
add_ram  output  ADDR_W  RAM address.
add_rom  output  ADDR_W  ROM (coefficient) address.
ld1  output  1  load the coefficient operand register.
ld2  output  1  load the sample operand register.
acc_clr  output  1  synchronously clear the accumulator.
acc_en  output  1  accumulator adds the multiplier product.
out_valid  output  1  one-cycle pulse: accumulator holds the completed y[n].
busy  output  1  high in every state except IDLE.

Behaviour:
- Moore machine: all outputs decode from state, tap counter k and write pointer wptr. Datapath ROM/RAM reads are combinational; RAM writes occur on the clock edge.
- Reset:
  - While global_reset=1, every output is forced to 0, including in_ready.
  - On the next edge: state=IDLE, k=0, wptr=0.
  - Reset asserted mid-operation aborts immediately. No out_valid is issued. The delay-line contents are not cleared.
- States:
  - IDLE: in_ready=1. Address outputs are 0.
    - If flush=1, go to FLUSH. flush has priority over in_valid.
    - Else if in_valid=1, go to WRITE.
  - WRITE (1 cycle): wr=1, add_ram=wptr, acc_clr=1. Then go to MAC with k=0.
  - MAC (TAPS cycles):
    - add_rom=k; add_ram=(wptr-k) wrapped into 0..TAPS-1 by explicit add-TAPS, not bit truncation.
    - ld1=ld2=1.
    - acc_en=1 on every MAC cycle except k=0, because the product lags ld by one cycle.
    - k increments each cycle. After k=TAPS-1, go to DRAIN.
  - DRAIN (1 cycle): acc_en=1 for the final product. Go to DONE.
  - DONE (1 cycle): out_valid=1. wptr advances to wptr+1, wrapping TAPS-1 -> 0. Go to IDLE.
  - FLUSH (TAPS cycles): wr=1, zero_sel=1, add_ram=k for k=0..TAPS-1. On exit wptr=0, k=0, go to IDLE. No out_valid is issued.
- Latency: handshake in cycle T -> out_valid in cycle T+TAPS+3. Throughput is one sample per TAPS+4 cycles.
- in_valid while in_ready=0 is ignored; the upstream block must hold the sample.
- zero_sel=0 and wr=0 in every state other than those listed above.
- The newest sample is always at tap 0: the RAM write in WRITE completes before the first MAC read.

Decomposition:
- Shared package fir_pkg contains:
  - enum seq_state_t {IDLE, WRITE, MAC, DRAIN, FLUSH, DONE};
  - default TAPS;
  - a function computing the wrapped address (a-b) mod TAPS.
- One natural sub-module, fir_tap_addr_gen, owns:
  - tap counter k with terminal-count flag;
  - wptr register with increment/clear;
  - wrapped RAM-address subtractor.
  The top level owns the FSM and output decode.

Test Plan:
1. Reset: hold global_reset for 3 cycles while in_valid=1 -> all outputs 0 during reset; cycle after release in_ready=1, busy=0, wptr=0.
2. Single sample, TAPS=4: in_valid at T ->
   - T+1: wr=1, add_ram=0, acc_clr=1.
   - T+2..T+5: add_rom=0,1,2,3 and add_ram=0,3,2,1.
   - acc_en high on T+3..T+6.
   - out_valid only at T+7.
   - in_ready returns at T+8.
3. Wrap: feed 5 back-to-back samples, x=1,2,3,4,5, with ROM={1,1,1,1} and a model accumulator -> outputs 1,3,6,10,14; 5th sample written at add_ram=0.
4. Flush priority: flush=1 and in_valid=1 together in IDLE ->
   - FLUSH chosen: 4 cycles wr=1, zero_sel=1, add_ram 0..3, no out_valid.
   - Next sample x=7 yields 7 (coefficient 1 at tap 0), rest zero.
5. Mid-operation reset: assert global_reset during MAC k=2 -> no out_valid; next cycle after release is IDLE with in_ready=1.
6. Backpressure: hold in_valid=1 continuously -> exactly one accept per TAPS+4 cycles; in_ready low throughout busy.
